renode_apb3_completer: RTL and testbench

RENODE_APB3_COMPLETER -- requirements
Module: renode_apb3_completer

---
 rtl/renode_apb3_completer.sv | 151 +++++++++++++++
 tb/tb_renode_apb3_completer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renode_apb3_completer.sv
// APB3 completer that forwards each transfer to a Renode-side request/response channel.
// A timeout turns a lost request or response into a slave error instead of a hung bus.
module renode_apb3_completer #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [AddressWidth-1:0] req_addr,
    output logic [DataWidth-1:0]    req_wdata,
    input  logic                    rsp_valid,
    input  logic [DataWidth-1:0]    rsp_rdata,
    input  logic                    rsp_error,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    localparam logic [15:0] CntLoad = 16'(TimeoutCycles - 1);

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [AddressWidth-1:0] req_addr_q, req_addr_d;
    logic                    req_write_q, req_write_d;
    logic [DataWidth-1:0]    req_wdata_q, req_wdata_d;
    logic [DataWidth-1:0]    prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;

    logic [15:0] cnt_dec;
    logic        expired;

    // The counter saturates at zero so a late handshake on the final cycle cannot wrap it.
    assign expired = (cnt_q == 16'd0);
    assign cnt_dec = expired ? 16'd0 : cnt_q - 16'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_wdata_d = req_wdata_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;

        case (state_q)
            S_IDLE: begin
                if (pselx && !penable) begin
                    state_d     = S_REQ;
                    req_addr_d  = paddr;
                    req_write_d = pwrite;
                    req_wdata_d = pwrite ? pwdata : '0;
                    cnt_d       = CntLoad;
                end
            end
            S_REQ: begin
                cnt_d = cnt_dec;
                if (req_ready) begin
                    state_d = S_WAIT;
                end else if (!pselx) begin
                    // Nothing was accepted, so the drain only needs a single cycle.
                    state_d = S_DRAIN;
                    cnt_d   = 16'd0;
                end else if (expired) begin
                    state_d   = S_DONE;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_dec;
                if (!pselx) begin
                    state_d = S_DRAIN;
                    if (rsp_valid) begin
                        cnt_d = 16'd0;
                    end
                end else if (rsp_valid) begin
                    state_d   = S_DONE;
                    prdata_d  = req_write_q ? '0 : rsp_rdata;
                    pslverr_d = rsp_error;
                end else if (expired) begin
                    state_d   = S_DONE;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                prdata_d  = '0;
                pslverr_d = 1'b0;
            end
            S_DRAIN: begin
                cnt_d = cnt_dec;
                if (rsp_valid || expired) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_wdata_q <= req_wdata_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
        end
    end

    // pready is masked if a requester presents a setup phase during the completion cycle.
    assign pready    = (state_q == S_DONE) && !(pselx && !penable);
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign req_valid = (state_q == S_REQ);
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_renode_apb3_completer.sv
// Self-checking bench for renode_apb3_completer: a transaction-level timing model predicts
// every output each cycle; directed cases pin the model, then randomized transfers follow.
module tb_renode_apb3_completer;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic          pselx = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    logic          rsp_error = 1'b0;
    logic          busy;

    renode_apb3_completer #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .TimeoutCycles(T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .paddr    (paddr),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pready_start = -1;
    bit chk_en = 1'b0;

    logic          exp_pready = 1'b0;
    logic [DW-1:0] exp_prdata = '0;
    logic          exp_pslverr = 1'b0;
    logic          exp_req_valid = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_req_write = 1'b0;
    logic [AW-1:0] exp_req_addr = '0;
    logic [DW-1:0] exp_req_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Every cycle, away from the rising edge, compare the DUT against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("pready", 32'(pready), 32'(exp_pready));
            checkOutput("prdata", 32'(prdata), 32'(exp_prdata));
            checkOutput("pslverr", 32'(pslverr), 32'(exp_pslverr));
            checkOutput("req_valid", 32'(req_valid), 32'(exp_req_valid));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            if (exp_req_valid) begin
                checkOutput("req_addr", 32'(req_addr), 32'(exp_req_addr));
                checkOutput("req_write", 32'(req_write), 32'(exp_req_write));
                checkOutput("req_wdata", 32'(req_wdata), 32'(exp_req_wdata));
            end
            if (pready === 1'b1) pready_start = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdleExp();
        exp_pready    = 1'b0;
        exp_prdata    = '0;
        exp_pslverr   = 1'b0;
        exp_req_valid = 1'b0;
        exp_busy      = 1'b0;
    endtask

    // Timing model, cycles counted from the edge that samples the setup phase (cycle 0 = first
    // request cycle). rdy: cycle req_ready is offered; rsp: cycle rsp_valid pulses (-1 none);
    // drop: first cycle pselx is low (-1 none). A request lives for T cycles at most.
    function automatic void computeModel(input int rdy, input int rsp, input int drop,
                                         output int req_last, output int done,
                                         output int idle, output bit acc);
        int x;
        int e;
        acc  = 1'b0;
        done = -1;
        idle = 0;
        if (drop >= 0 && drop < rdy && drop <= T - 1) begin
            req_last = drop;
            idle     = drop + 2;
        end else if (rdy >= T) begin
            req_last = T - 1;
            done     = T;
        end else begin
            req_last = rdy;
            x = (T - 1 > rdy + 1) ? T - 1 : rdy + 1;
            if (rsp >= rdy + 1 && rsp <= x && (drop < 0 || rsp < drop)) begin
                acc  = 1'b1;
                done = rsp + 1;
            end else if (drop >= 0 && drop <= x) begin
                if (rsp == drop) begin
                    e = drop + 1;
                end else begin
                    e = (T - 1 > drop + 1) ? T - 1 : drop + 1;
                    if (rsp >= drop + 1 && rsp < e) e = rsp;
                end
                idle = e + 1;
            end else begin
                done = x + 1;
            end
        end
        if (done >= 0) idle = done + 1;
    endfunction

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                 input logic er, input int rdy, input int rsp, input int drop,
                                 output int done, output int setup_c);
        int  req_last;
        int  idle;
        bit  acc;
        computeModel(rdy, rsp, drop, req_last, done, idle, acc);
        pready_start = -1;
        setup_c   = cyc;
        pselx     = 1'b1;
        penable   = 1'b0;
        paddr     = addr;
        pwrite    = wr;
        pwdata    = wd;
        req_ready = 1'($urandom_range(0, 1));
        rsp_valid = 1'($urandom_range(0, 1));
        rsp_rdata = $urandom;
        rsp_error = 1'($urandom_range(0, 1));
        exp_req_addr  = addr;
        exp_req_write = wr;
        exp_req_wdata = wr ? wd : '0;
        tick();
        for (int k = 0; k < idle; k++) begin
            exp_req_valid = (k <= req_last);
            exp_busy      = 1'b1;
            exp_pready    = (k == done);
            exp_pslverr   = (k == done) ? (acc ? er : 1'b1) : 1'b0;
            exp_prdata    = (k == done && acc && !wr) ? rd : '0;
            pselx     = !(drop >= 0 && k >= drop);
            penable   = pselx;
            paddr     = AW'($urandom);
            pwrite    = 1'($urandom_range(0, 1));
            pwdata    = $urandom;
            req_ready = (k == rdy);
            rsp_valid = (k == rsp);
            rsp_rdata = (k == rsp) ? rd : $urandom;
            rsp_error = (k == rsp) ? er : 1'($urandom_range(0, 1));
            tick();
        end
        setIdleExp();
    endtask

    task automatic idleCycles(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            pselx     = 1'b0;
            penable   = 1'b0;
            paddr     = AW'($urandom);
            pwrite    = 1'($urandom_range(0, 1));
            req_ready = 1'($urandom_range(0, 1));
            rsp_valid = spur;
            rsp_rdata = $urandom;
            rsp_error = 1'($urandom_range(0, 1));
            tick();
        end
        rsp_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pready"}, 32'(pready), 32'd0);
        checkOutput({tag, "_prdata"}, 32'(prdata), 32'd0);
        checkOutput({tag, "_pslverr"}, 32'(pslverr), 32'd0);
        checkOutput({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        checkOutput({tag, "_req_write"}, 32'(req_write), 32'd0);
        checkOutput({tag, "_req_addr"}, 32'(req_addr), 32'd0);
        checkOutput({tag, "_req_wdata"}, 32'(req_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done;
        int setup_c;
        int rdy;
        int rsp;
        int drop;
        int r;
        logic wr;

        #1;
        checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        setIdleExp();
        chk_en = 1'b1;
        idleCycles(2, 1'b1);

        // Write with immediate handshake and a first-cycle response.
        applyStimulus(1'b1, 20'h00010, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 0, 1, -1, done, setup_c);
        checkOutput("model_write_done", 32'(done), 32'd2);
        checkOutput("write_latency", 32'(pready_start + 1 - setup_c), 32'd4);
        idleCycles(1, 1'b0);

        // Read with req_ready held off for three cycles.
        applyStimulus(1'b0, 20'h00400, 32'h0BADF00D, 32'h12345678, 1'b0, 3, 4, -1, done, setup_c);
        checkOutput("model_read_done", 32'(done), 32'd5);
        checkOutput("read_prdata_after", 32'(prdata), 32'd0);
        idleCycles(1, 1'b0);

        // Timeout while waiting, then a late response two cycles after pready.
        applyStimulus(1'b0, 20'h00abc, 32'h0, 32'h55555555, 1'b0, 0, -1, -1, done, setup_c);
        checkOutput("model_timeout_done", 32'(done), 32'd8);
        checkOutput("timeout_cycles", 32'(pready_start - (setup_c + 1)), 32'd8);
        idleCycles(1, 1'b0);
        idleCycles(1, 1'b1);
        idleCycles(1, 1'b0);

        // Timeout in the request phase: req_ready never offered.
        applyStimulus(1'b1, 20'h00020, 32'h11112222, 32'h0, 1'b0, 20, 3, -1, done, setup_c);
        checkOutput("model_req_timeout_done", 32'(done), 32'd8);

        // Error response on a read, back-to-back with the previous transfer.
        applyStimulus(1'b0, 20'h00044, 32'h0, 32'hA5A5A5A5, 1'b1, 1, 3, -1, done, setup_c);
        checkOutput("model_error_done", 32'(done), 32'd4);

        // Abort in the wait phase; the drain ends on the response.
        applyStimulus(1'b0, 20'h00088, 32'h0, 32'h77777777, 1'b0, 0, 4, 2, done, setup_c);
        checkOutput("abort_no_pready", 32'(pready_start), 32'hFFFFFFFF);
        checkOutput("abort_busy_after", 32'(busy), 32'd0);
        idleCycles(1, 1'b0);

        // Abort in the request phase.
        applyStimulus(1'b1, 20'h00099, 32'h13572468, 32'h0, 1'b0, 5, -1, 1, done, setup_c);
        checkOutput("abort_req_no_pready", 32'(pready_start), 32'hFFFFFFFF);
        idleCycles(1, 1'b0);

        // Reset pulsed while waiting for a response.
        chk_en    = 1'b0;
        pselx     = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 20'h00123;
        pwdata    = 32'h99998888;
        tick();
        penable   = 1'b1;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        setIdleExp();
        chk_en = 1'b1;
        tick();
        rsp_valid = 1'b0;
        checkOutput("rst_no_req", 32'(req_valid), 32'd0);
        idleCycles(1, 1'b0);
        applyStimulus(1'b0, 20'h00400, 32'h0, 32'h0F0F0F0F, 1'b0, 0, 1, -1, done, setup_c);
        checkOutput("rst_read_latency", 32'(pready_start + 1 - setup_c), 32'd4);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 10))
                                              : int'($urandom_range(0, 4));
            r   = int'($urandom_range(0, 9));
            if (r == 0)      rsp = -1;
            else if (r == 1) rsp = int'($urandom_range(0, rdy));
            else             rsp = rdy + 1 + int'($urandom_range(0, 8));
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1;
            if (drop == rdy) drop = -1;
            applyStimulus(wr, AW'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                          rdy, rsp, drop, done, setup_c);
            if ($urandom_range(0, 2) != 0) idleCycles(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
        end

        idleCycles(2, 1'b0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
